leddc_pwm_engine: RTL and testbench



---
 rtl/leddc_pwm_engine.sv | 152 +++++++++++++++
 tb/tb_leddc_pwm_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leddc_pwm_engine.sv
`default_nettype none
// ============================================================================
// Module   : leddc_pwm_engine
// Brief    : Double-buffered grayscale PWM engine, GCK domain, ROUNDS-way split.
//            Optional global dimming when LEDDC_GLOBAL_DIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module leddc_pwm_engine #(
    parameter int CH     = 16,
    parameter int LINES  = 32,
    parameter int GS_W   = 16,
    parameter int ROUNDS = 2,
    localparam int RW    = $clog2(ROUNDS),
    localparam int RIW   = (RW > 0) ? RW : 1,
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             GCK,
    input  logic             rst,
    input  logic             Vsync,
    input  logic             wr_en,
    input  logic [LW-1:0]    wr_line,
    input  logic [CW-1:0]    wr_ch,
    input  logic [GS_W-1:0]  wr_data,
    input  logic             swap_req,
`ifdef LEDDC_GLOBAL_DIM_EN
    input  logic [7:0]       dim,
`endif
    output logic [CH-1:0]    OUT,
    output logic [LW-1:0]    line_sel,
    output logic [RIW-1:0]   round_idx,
    output logic             frame_done,
    output logic             swap_pend
);

    localparam int             CNTW       = GS_W - RW + 1;
    localparam logic [CNTW-1:0] P_CNT     = CNTW'(1) << (CNTW - 1);
    localparam logic [GS_W-1:0] RMASK     = GS_W'(ROUNDS - 1);
    localparam logic [LW:0]     LINES_LIM = (LW + 1)'(LINES);
    localparam logic [CW:0]     CH_LIM    = (CW + 1)'(CH);
    localparam logic [LW-1:0]   LINE_LAST = LW'(LINES - 1);
    localparam logic [RIW-1:0]  RND_LAST  = RIW'(ROUNDS - 1);

    logic [GS_W-1:0] fb [2][LINES][CH];
    logic            front_sel;
    logic            vsync_q;
    logic [CNTW-1:0] cnt;
    logic [CH-1:0]   out_next;
    logic            wr_ok;
    logic            period_end;
    logic            swap_apply;

    assign wr_ok      = wr_en && ({1'b0, wr_line} < LINES_LIM) && ({1'b0, wr_ch} < CH_LIM);
    assign period_end = vsync_q && !Vsync;
    assign swap_apply = swap_pend && !Vsync && (line_sel == '0) && (round_idx == '0);

`ifdef LEDDC_GLOBAL_DIM_EN
    logic [7:0] dim_q;
    logic [7:0] dim_cur;
    // The first high edge of a period uses the live dim; later edges reuse the latched copy.
    assign dim_cur = (Vsync && !vsync_q) ? dim : dim_q;

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            dim_q <= '0;
        end else begin
            dim_q <= dim_cur;
        end
    end
`endif

    for (genvar c = 0; c < CH; c++) begin : g_share
        logic [GS_W-1:0] word;
        logic [GS_W-1:0] rem;
        logic [CNTW-1:0] share;
        logic [CNTW-1:0] eff;

        assign word  = fb[front_sel][line_sel][c];
        assign rem   = word & RMASK;
        // The low RW bits are spread one-per-round over the first rem rounds.
        assign share = CNTW'(word >> RW) + CNTW'(GS_W'(round_idx) < rem);
`ifdef LEDDC_GLOBAL_DIM_EN
        logic [CNTW+7:0] prod;
        assign prod = (CNTW + 8)'(share) * (CNTW + 8)'(9'(dim_cur) + 9'd1);
        assign eff  = CNTW'(prod >> 8);
`else
        assign eff  = share;
`endif
        assign out_next[c] = (cnt < eff);
    end

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < LINES; l++) begin
                    for (int c = 0; c < CH; c++) begin
                        fb[b][l][c] <= '0;
                    end
                end
            end
        end else if (wr_ok) begin
            fb[~front_sel][wr_line][wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            OUT        <= '0;
            cnt        <= '0;
            vsync_q    <= 1'b0;
            line_sel   <= '0;
            round_idx  <= '0;
            frame_done <= 1'b0;
            swap_pend  <= 1'b0;
            front_sel  <= 1'b0;
        end else begin
            vsync_q    <= Vsync;
            frame_done <= 1'b0;

            if (Vsync) begin
                OUT <= out_next;
                cnt <= (cnt == P_CNT) ? P_CNT : cnt + CNTW'(1);
            end else begin
                OUT <= '0;
                cnt <= '0;
            end

            if (period_end) begin
                if (line_sel == LINE_LAST) begin
                    line_sel <= '0;
                    if (round_idx == RND_LAST) begin
                        round_idx  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        round_idx <= round_idx + RIW'(1);
                    end
                end else begin
                    line_sel <= line_sel + LW'(1);
                end
            end

            if (swap_apply) begin
                front_sel <= ~front_sel;
                swap_pend <= swap_req;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leddc_pwm_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_leddc_pwm_engine
// Brief    : Scoreboard bench for leddc_pwm_engine on a small 3ch/3line/8bit/4round geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leddc_pwm_engine;

    localparam int CH     = 3;
    localparam int LINES  = 3;
    localparam int GS_W   = 8;
    localparam int ROUNDS = 4;
    localparam int P      = 64;
    localparam int LW     = 2;
    localparam int CW     = 2;
    localparam int RIW    = 2;

    logic             GCK      = 1'b0;
    logic             rst      = 1'b1;
    logic             Vsync    = 1'b0;
    logic             wr_en    = 1'b0;
    logic [LW-1:0]    wr_line  = '0;
    logic [CW-1:0]    wr_ch    = '0;
    logic [GS_W-1:0]  wr_data  = '0;
    logic             swap_req = 1'b0;
    logic [CH-1:0]    OUT;
    logic [LW-1:0]    line_sel;
    logic [RIW-1:0]   round_idx;
    logic             frame_done;
    logic             swap_pend;

    leddc_pwm_engine #(
        .CH     (CH),
        .LINES  (LINES),
        .GS_W   (GS_W),
        .ROUNDS (ROUNDS)
    ) dut (
        .GCK        (GCK),
        .rst        (rst),
        .Vsync      (Vsync),
        .wr_en      (wr_en),
        .wr_line    (wr_line),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .OUT        (OUT),
        .line_sel   (line_sel),
        .round_idx  (round_idx),
        .frame_done (frame_done),
        .swap_pend  (swap_pend)
    );

    always #5 GCK = ~GCK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame buffers, display position and pending swap.
    int m_buf [2][LINES][CH];
    int m_front;
    int m_line;
    int m_round;
    bit m_pend;

    typedef struct packed {
        logic [CH-1:0][7:0] cnt;
        logic [LW-1:0]      line;
        logic [RIW-1:0]     rnd;
        logic               fd;
        logic               pend;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    function automatic int exp_high(input int v, input int k, input int len);
        int s;
        s = v / ROUNDS + ((k < v % ROUNDS) ? 1 : 0);
        return (s < len) ? s : len;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < LINES; l++)
                for (int c = 0; c < CH; c++)
                    m_buf[b][l][c] = 0;
        m_front = 0;
        m_line  = 0;
        m_round = 0;
        m_pend  = 1'b0;
        exp_q.delete();
    endtask

    // One GCK edge with the currently driven inputs, mirrored into the model.
    task automatic step();
        bit apply;
        apply = m_pend && !Vsync && (m_line == 0) && (m_round == 0);
        if (wr_en && int'(wr_line) < LINES && int'(wr_ch) < CH)
            m_buf[1 - m_front][int'(wr_line)][int'(wr_ch)] = int'(wr_data);
        if (apply) begin
            m_front = 1 - m_front;
            m_pend  = swap_req;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        @(posedge GCK);
        #1;
    endtask

    task automatic wr(input int l, input int c, input int d);
        wr_en   = 1'b1;
        wr_line = LW'(l);
        wr_ch   = CW'(c);
        wr_data = GS_W'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic swap_pulse();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic run_period(input int gap, input int len, input int swap_at);
        exp_t e;
        e = '0;
        Vsync = 1'b0;
        repeat (gap) step();
        for (int c = 0; c < CH; c++)
            e.cnt[c] = 8'(exp_high(m_buf[m_front][m_line][c], m_round, len));
        Vsync = 1'b1;
        for (int i = 0; i < len; i++) begin
            swap_req = (i == swap_at);
            step();
        end
        swap_req = 1'b0;
        Vsync    = 1'b0;
        step();
        e.fd = (m_line == LINES - 1) && (m_round == ROUNDS - 1);
        if (m_line == LINES - 1) begin
            m_line  = 0;
            m_round = (m_round + 1) % ROUNDS;
        end else begin
            m_line++;
        end
        e.line = LW'(m_line);
        e.rnd  = RIW'(m_round);
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    // Monitor: a change of display position marks a completed period.
    initial begin
        int   acc [CH];
        int   fd_spur;
        int   prev_line;
        int   prev_rnd;
        exp_t e;
        fd_spur   = 0;
        prev_line = 0;
        prev_rnd  = 0;
        for (int c = 0; c < CH; c++) acc[c] = 0;
        forever begin
            @(negedge GCK);
            if (!mon_en) begin
                prev_line = 0;
                prev_rnd  = 0;
                fd_spur   = 0;
                for (int c = 0; c < CH; c++) acc[c] = 0;
            end else begin
                if (int'(line_sel) != prev_line || int'(round_idx) != prev_rnd) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_period_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int c = 0; c < CH; c++)
                            check($sformatf("high_cycles_ch%0d", c), acc[c], int'(e.cnt[c]));
                        check("line_sel", int'(line_sel), int'(e.line));
                        check("round_idx", int'(round_idx), int'(e.rnd));
                        check("frame_done", int'(frame_done), int'(e.fd));
                        check("swap_pend", int'(swap_pend), int'(e.pend));
                        check("frame_done_spurious", fd_spur, 0);
                    end
                    fd_spur = 0;
                    for (int c = 0; c < CH; c++) acc[c] = 0;
                end else if (frame_done) begin
                    fd_spur++;
                end
                for (int c = 0; c < CH; c++)
                    if (OUT[c]) acc[c]++;
                prev_line = int'(line_sel);
                prev_rnd  = int'(round_idx);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_OUT"}, int'(OUT), 0);
        check({tag, "_line_sel"}, int'(line_sel), 0);
        check({tag, "_round_idx"}, int'(round_idx), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_swap_pend"}, int'(swap_pend), 0);
    endtask

    initial begin
        int len;
        int sw;
        #1 rst = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("reset");
        @(posedge GCK);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Directed frame: full, minimum, half and zero-ish values, plus ignored writes.
        wr(0, 0, 8'hFF);
        wr(0, 1, 8'h01);
        wr(0, 2, 8'h80);
        wr(1, 0, 8'h07);
        wr(3, 0, 8'h4D);
        wr(1, 3, 8'h63);
        swap_pulse();
        repeat (2) step();
        repeat (LINES * ROUNDS) run_period(2, P, -1);

        // Blanking beyond P edges, then single-edge periods.
        run_period(2, P + 30, -1);
        run_period(3, 1, -1);
        run_period(1, 1, -1);
        while (!(m_line == 0 && m_round == 0)) run_period(2, P, -1);

        // Deferred swap requested during line 1 of round 0.
        for (int c = 0; c < CH; c++) wr(0, c, 8'h30 + c);
        wr(2, 1, 8'hC3);
        run_period(2, P, -1);
        run_period(2, P, 17);
        repeat (LINES * ROUNDS - 2) run_period(2, P, -1);
        repeat (LINES) run_period(2, P, -1);
        while (!(m_line == 0 && m_round == 0)) run_period(2, P, -1);

        // Randomized frames with random writes, swaps and period lengths.
        for (int f = 0; f < 5; f++) begin
            for (int p = 0; p < LINES * ROUNDS; p++) begin
                repeat ($urandom_range(0, 2))
                    wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
                if ($urandom_range(0, 5) == 0) swap_pulse();
                case ($urandom_range(0, 3))
                    0:       len = P;
                    1:       len = 1;
                    2:       len = $urandom_range(2, P - 1);
                    default: len = P + $urandom_range(1, 10);
                endcase
                sw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
                run_period($urandom_range(1, 3), len, sw);
            end
        end

        // Asynchronous reset in the middle of an active period.
        Vsync = 1'b1;
        repeat (5) step();
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midperiod_reset");
        model_clear();
        @(posedge GCK);
        #1;
        Vsync  = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Cleared buffers display nothing, then fresh data shows after a swap.
        swap_pulse();
        repeat (LINES) run_period(2, P, -1);
        while (!(m_line == 0 && m_round == 0)) run_period(2, P, -1);
        wr(0, 0, 8'hA5);
        wr(1, 2, 8'h0B);
        swap_pulse();
        repeat (LINES * ROUNDS) run_period(2, P, -1);

        Vsync = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge GCK);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
